// File: rtl/adaptor_pkg.sv
// Shared definitions for the burst line adaptor.
//   adaptor_state_t : FSM state encoding (IDLE, RD_BURST, WR_BURST, DONE)
//   LINE_WIDTH      : cacheline width in bits
//   BURST_WIDTH     : memory beat width in bits
//   BURSTS          : beats per cacheline
//   OFFSET_BITS     : byte-offset bits cleared for line alignment
package adaptor_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BURSTS      = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adaptor_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide register addressable one beat at a time.
//   clk, rst    : clock, asynchronous active-high reset (clears the line)
//   load        : load the full line from load_line (takes priority)
//   load_line   : full-line data for load
//   beat_we     : write beat_wdata into slice beat_sel
//   beat_sel    : beat index for both the slice write and the beat output
//   beat_wdata  : beat data for the slice write
//   line        : registered line contents
//   beat        : slice beat_sel of the registered line (combinational)
module line_beat_buffer #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int SEL_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [LINE_WIDTH-1:0]  load_line,
  input  logic                   beat_we,
  input  logic [SEL_W-1:0]       beat_sel,
  input  logic [BURST_WIDTH-1:0] beat_wdata,
  output logic [LINE_WIDTH-1:0]  line,
  output logic [BURST_WIDTH-1:0] beat
);

  logic [LINE_WIDTH-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_line;
    end else if (beat_we) begin
      line_q[int'(beat_sel)*BURST_WIDTH +: BURST_WIDTH] <= beat_wdata;
    end
  end

  assign line = line_q;
  assign beat = line_q[int'(beat_sel)*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: rtl/burst_line_adaptor.sv
// Converts one cacheline request from the cache arbiter into a multi-beat
// burst on the physical-memory port. One request in flight at a time.
//   clk, rst   : clock, asynchronous active-high reset
//   address_i  : line request address
//   read_i     : line read request
//   write_i    : line write request (wins over read_i)
//   line_i     : write-back line data
//   line_o     : assembled read line (holds last read line)
//   resp_o     : one-cycle completion pulse
//   address_o  : line-aligned memory address, stable for the whole burst
//   read_o     : memory burst read
//   write_o    : memory burst write
//   burst_o    : current write beat
//   burst_i    : read beat from memory
//   resp_i     : memory beat valid/accepted, one per beat
module burst_line_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
);

  localparam int BURSTS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W  = (BURSTS > 1) ? $clog2(BURSTS) : 1;

  import adaptor_pkg::*;

  adaptor_state_t        state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  read_q;
  logic                  write_q;
  logic                  resp_q;
  logic [7:0]            proto_viol_q;

  logic [ADDR_WIDTH-1:0]  aligned_addr;
  logic                   last_beat;
  logic                   rd_beat_we;
  logic                   wr_load;
  logic [BURST_WIDTH-1:0] rd_beat_unused;
  logic [LINE_WIDTH-1:0]  wr_line_unused;

  assign aligned_addr = address_i & ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
  assign last_beat    = (cnt_q == CNT_W'(BURSTS - 1));
  assign rd_beat_we   = (state_q == RD_BURST) && resp_i;
  assign wr_load      = (state_q == IDLE) && write_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      resp_q       <= 1'b0;
      proto_viol_q <= '0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (write_i) begin
            addr_q  <= aligned_addr;
            write_q <= 1'b1;
            state_q <= WR_BURST;
          end else if (read_i) begin
            addr_q  <= aligned_addr;
            read_q  <= 1'b1;
            state_q <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // A memory response here has no beat to belong to; it is only tallied.
          if (resp_i && (proto_viol_q != '1)) begin
            proto_viol_q <= proto_viol_q + 8'd1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read beats land in their own line so that a write never disturbs line_o.
  line_beat_buffer #(
    .LINE_WIDTH  (LINE_WIDTH),
    .BURST_WIDTH (BURST_WIDTH),
    .SEL_W       (CNT_W)
  ) u_rd_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (1'b0),
    .load_line  ('0),
    .beat_we    (rd_beat_we),
    .beat_sel   (cnt_q),
    .beat_wdata (burst_i),
    .line       (line_o),
    .beat       (rd_beat_unused)
  );

  line_beat_buffer #(
    .LINE_WIDTH  (LINE_WIDTH),
    .BURST_WIDTH (BURST_WIDTH),
    .SEL_W       (CNT_W)
  ) u_wr_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (wr_load),
    .load_line  (line_i),
    .beat_we    (1'b0),
    .beat_sel   (cnt_q),
    .beat_wdata ('0),
    .line       (wr_line_unused),
    .beat       (burst_o)
  );

  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_burst_line_adaptor.sv
module tb_burst_line_adaptor;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_line = '0;

  burst_line_adaptor #(
    .LINE_WIDTH  (256),
    .BURST_WIDTH (64),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic start_read(input logic [31:0] addr);
    @(negedge clk);
    address_i = addr;
    read_i    = 1'b1;
  endtask

  // pat bit i = resp_i in the i-th burst cycle; it must hold exactly four ones.
  task automatic finish_read(input logic [31:0] addr_exp, input logic [255:0] exp_line,
                             input logic [15:0] pat, input int n, input bit hold);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rd_read_o_high", 256'(read_o), 256'd1);
      check("rd_resp_o_low", 256'(resp_o), 256'd0);
      if (i == 0) check("rd_address_o", 256'(address_o), 256'(addr_exp));
      if (!hold) read_i = 1'b0;
      resp_i  = pat[i];
      burst_i = pat[i] ? exp_line[k*64 +: 64] : JUNK;
      if (pat[i]) k++;
    end
    @(negedge clk);
    resp_i  = 1'b0;
    burst_i = JUNK;
    check("rd_resp_o_pulse", 256'(resp_o), 256'd1);
    check("rd_read_o_dropped", 256'(read_o), 256'd0);
    check("rd_line_o", line_o, exp_line);
    last_line = exp_line;
    @(negedge clk);
    check("rd_resp_o_single", 256'(resp_o), 256'd0);
    check("rd_read_o_idle", 256'(read_o), 256'd0);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] addr_exp,
                           input logic [255:0] wline, input bit both);
    @(negedge clk);
    address_i = addr;
    write_i   = 1'b1;
    read_i    = both;
    line_i    = wline;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 0) begin
        check("wr_address_o", 256'(address_o), 256'(addr_exp));
        write_i = 1'b0;
        read_i  = 1'b0;
        line_i  = '0;
      end
      check("wr_write_o_high", 256'(write_o), 256'd1);
      check("wr_read_o_low", 256'(read_o), 256'd0);
      check("wr_burst_o", 256'(burst_o), 256'(wline[b*64 +: 64]));
      resp_i = 1'b1;
    end
    @(negedge clk);
    resp_i = 1'b0;
    check("wr_resp_o_pulse", 256'(resp_o), 256'd1);
    check("wr_write_o_dropped", 256'(write_o), 256'd0);
    check("wr_read_o_never", 256'(read_o), 256'd0);
    check("wr_line_o_untouched", line_o, last_line);
    @(negedge clk);
    check("wr_resp_o_single", 256'(resp_o), 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = '0;
    burst_i   = JUNK;
    resp_i    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_line_o", line_o, 256'd0);
    check("rst_resp_o", 256'(resp_o), 256'd0);
    check("rst_address_o", 256'(address_o), 256'd0);
    check("rst_read_o", 256'(read_o), 256'd0);
    check("rst_write_o", 256'(write_o), 256'd0);
    check("rst_burst_o", 256'(burst_o), 256'd0);
    rst = 1'b0;

    // resp_i while idle must not start anything
    @(negedge clk);
    resp_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b0;
    check("idle_resp_read_o", 256'(read_o), 256'd0);
    check("idle_resp_write_o", 256'(write_o), 256'd0);
    @(negedge clk);
    check("idle_resp_resp_o", 256'(resp_o), 256'd0);

    // consecutive-beat read
    start_read(32'h0000_1234);
    finish_read(32'h0000_1220,
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                16'h000F, 4, 1'b0);

    // write: beats go out low slice first, line_o keeps the last read line
    run_write(32'h0000_0080, 32'h0000_0080,
              256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA, 1'b0);

    // read with stalls 1,0,0,1,1,0,1
    start_read(32'h0000_301F);
    finish_read(32'h0000_3000,
                256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555,
                16'h0059, 7, 1'b0);

    // read and write together: write wins
    run_write(32'h0000_0100, 32'h0000_0100,
              256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0, 1'b1);

    // reset after two beats of a read
    start_read(32'h0000_0040);
    @(negedge clk);
    check("mid_rst_read_o_up", 256'(read_o), 256'd1);
    resp_i  = 1'b1;
    burst_i = 64'h9999999999999999;
    read_i  = 1'b0;
    @(negedge clk);
    burst_i = 64'hAAAA5555AAAA5555;
    @(negedge clk);
    resp_i  = 1'b0;
    burst_i = JUNK;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_read_o", 256'(read_o), 256'd0);
    check("mid_rst_resp_o", 256'(resp_o), 256'd0);
    check("mid_rst_line_o", line_o, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    last_line = '0;
    @(negedge clk);
    check("post_rst_resp_o", 256'(resp_o), 256'd0);
    start_read(32'h0000_0040);
    finish_read(32'h0000_0040,
                256'hF4F4F4F4F4F4F4F4_F3F3F3F3F3F3F3F3_F2F2F2F2F2F2F2F2_F1F1F1F1F1F1F1F1,
                16'h000F, 4, 1'b0);

    // back-to-back: read_i held through DONE, re-accepted only once idle
    start_read(32'h0000_0200);
    finish_read(32'h0000_0200,
                256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101,
                16'h000F, 4, 1'b1);
    finish_read(32'h0000_0200,
                256'hB4B4B4B4B4B4B4B4_B3B3B3B3B3B3B3B3_B2B2B2B2B2B2B2B2_B1B1B1B1B1B1B1B1,
                16'h000F, 4, 1'b0);

    @(negedge clk);
    check("final_read_o", 256'(read_o), 256'd0);
    check("final_write_o", 256'(write_o), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
